// File: rtl/ovi_pkg.sv
// Shared OVI types: default bus widths, the VPU queue entry and the issue/completed bus layouts.
package ovi_pkg;

  localparam int SB_W_DEF   = 5;
  localparam int INST_W_DEF = 32;
  localparam int CNT_W      = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [SB_W_DEF-1:0] sb_id;
    cnt_t                cnt;
  } vpu_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [SB_W_DEF-1:0]   sb_id;
    logic [INST_W_DEF-1:0] inst;
  } ovi_issue_t;

  typedef struct packed {
    logic                valid;
    logic [SB_W_DEF-1:0] sb_id;
  } ovi_completed_t;

endpackage

// File: rtl/vpu_countdown_queue.sv
// Circular queue of in-flight VPU instructions, each with its own countdown.
// The head pops as soon as its countdown is 0; younger entries wait at 0 behind it.
module vpu_countdown_queue
  import ovi_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int SB_W  = SB_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             push_req,
  input  logic [SB_W-1:0]  push_sb_id,
  input  cnt_t             push_cnt,
  output logic             pop,
  output logic             full,
  output logic [SB_W-1:0]  head_sb_id,
  output logic [OCC_W-1:0] count
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_n;
  logic [SB_W-1:0]  sb_q  [DEPTH];
  cnt_t             cnt_q [DEPTH];
  logic             push_acc;

  assign pop        = vld_q[rd_ptr] && (cnt_q[rd_ptr] == '0);
  assign full       = (count == DEPTH_C);
  assign push_acc   = push_req && (!full || pop);
  assign head_sb_id = sb_q[rd_ptr];

  // When full, the pop frees exactly the slot the push lands in, so push wins.
  always_comb begin
    vld_n = vld_q;
    if (pop)      vld_n[rd_ptr] = 1'b0;
    if (push_acc) vld_n[wr_ptr] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_q  <= '0;
      count  <= '0;
    end else begin
      vld_q <= vld_n;
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (cnt_q[i] != '0)) cnt_q[i] <= cnt_q[i] - cnt_t'(1);
    end
    if (push_acc) begin
      cnt_q[wr_ptr] <= push_cnt;
      sb_q[wr_ptr]  <= push_sb_id;
    end
  end

endmodule

// File: rtl/vpu_latency_model.sv
// Behavioural VPU stand-in: bounded in-order queue of issued instructions, one credit per completion.
// Optional macro VPU_VAR_LATENCY_EN adds 4*funct3 cycles of latency per instruction.
module vpu_latency_model
  import ovi_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int LATENCY = 8,
  parameter  int SB_W    = SB_W_DEF,
  parameter  int INST_W  = INST_W_DEF,
  localparam int OCC_W   = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ISSUE_VALID,
  input  logic [SB_W-1:0]   ISSUE_SB_ID,
  input  logic [INST_W-1:0] ISSUE_INST,
  output logic              ISSUE_CREDIT,
  output logic              COMPLETED_VALID,
  output logic [SB_W-1:0]   COMPLETED_SB_ID,
  output logic [OCC_W-1:0]  OCCUPANCY,
  output logic              OVERFLOW
);

  localparam cnt_t BASE_CNT = cnt_t'(LATENCY - 1);

  cnt_t            push_cnt;
  logic            pop;
  logic            full;
  logic [SB_W-1:0] head_sb_id;
  logic            cmpl_vld_p1;
  logic [SB_W-1:0] cmpl_sb_p1;
  logic            ovf_q;
  logic            unused_inst;

`ifdef VPU_VAR_LATENCY_EN
  function automatic cnt_t sat_add_cnt(input cnt_t base, input logic [2:0] funct3);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + (CNT_W + 1)'({funct3, 2'b00});
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign push_cnt    = sat_add_cnt(BASE_CNT, ISSUE_INST[14:12]);
  assign unused_inst = ^{ISSUE_INST[INST_W-1:15], ISSUE_INST[11:0]};
`else
  assign push_cnt    = BASE_CNT;
  assign unused_inst = ^ISSUE_INST;
`endif

  vpu_countdown_queue #(
    .DEPTH (DEPTH),
    .SB_W  (SB_W)
  ) u_queue (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .push_req   (ISSUE_VALID),
    .push_sb_id (ISSUE_SB_ID),
    .push_cnt   (push_cnt),
    .pop        (pop),
    .full       (full),
    .head_sb_id (head_sb_id),
    .count      (OCCUPANCY)
  );

  // Stage p1: completion and credit registered one edge after the head pops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmpl_vld_p1 <= 1'b0;
      cmpl_sb_p1  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cmpl_vld_p1 <= pop;
      if (pop) cmpl_sb_p1 <= head_sb_id;
      if (ISSUE_VALID && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign COMPLETED_VALID = cmpl_vld_p1;
  assign ISSUE_CREDIT    = cmpl_vld_p1;
  assign COMPLETED_SB_ID = cmpl_sb_p1;
  assign OVERFLOW        = ovf_q;

endmodule
